mem_wb_stage: RTL

//  MEM stage plus MEM/WB pipeline register. Consumes EX/MEM outputs: data-memory

---
 rtl/mem_wb_stage_pkg.sv | 23 ++
 rtl/mem_wb_stage_data_mem.sv | 33 +++
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the MEM stage / MEM-WB register slice:
//   - WB control field bit positions
//   - datapath and register-address widths
//   - MEM-stage access FSM state encoding
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int WB_W        = 2;

    // WB control bundle: {RegWrite, MemToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are never cleared by reset.
// Ports:
//   clk      in  clock (write on rising edge)
//   i_we     in  write enable
//   i_addr   in  word index
//   i_wdata  in  write data
//   o_rdata  out read data (combinational, reflects pre-write contents)
// ---------------------------------------------------------------------------
module data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int    DEPTH    = 256,
    parameter string INIT_HEX = ""
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM stage plus MEM/WB pipeline register. Performs the data-memory access
// (with optional extra wait cycles), resolves the branch and registers the
// write-back bundle.
// Ports:
//   clk, rst            clock, async active-high reset
//   WB                  {RegWrite, MemToReg}
//   Branch, ZeroFlag    branch in MEM / ALU zero flag
//   MemWrite, MemRead   store / load request
//   BranchInst          branch target
//   ALUresult           ALU result / byte address
//   Dato2               store data
//   DirWriteReg         destination register
//   flush               insert bubble into MEM/WB, abort in-flight access
//   PCSrc, BranchTarget branch decision / target (combinational)
//   Stall               hold upstream stages
//   O_WB, O_ReadData, O_ALUresult, O_DirWriteReg   MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int    DEPTH    = 256,
    parameter int    MEM_LAT  = 0,
    parameter string INIT_HEX = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB_W-1:0]       WB,
    input  logic                  Branch,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [DATA_W-1:0]     BranchInst,
    input  logic                  ZeroFlag,
    input  logic [DATA_W-1:0]     ALUresult,
    input  logic [DATA_W-1:0]     Dato2,
    input  logic [REG_ADDR_W-1:0] DirWriteReg,
    input  logic                  flush,
    output logic                  PCSrc,
    output logic [DATA_W-1:0]     BranchTarget,
    output logic                  Stall,
    output logic [WB_W-1:0]       O_WB,
    output logic [DATA_W-1:0]     O_ReadData,
    output logic [DATA_W-1:0]     O_ALUresult,
    output logic [REG_ADDR_W-1:0] O_DirWriteReg
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    mem_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_req, w_stall, w_complete, w_we;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    logic [WB_W-1:0]       r_wb;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_alu;
    logic [REG_ADDR_W-1:0] r_dst;

    assign w_req    = MemRead | MemWrite;
    // Byte-offset bits and address bits above the array wrap silently.
    assign w_idx    = ALUresult[AW+1:2];
    assign w_unused = ^{ALUresult[1:0], ALUresult[DATA_W-1:AW+2]};

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!flush && w_req && (MEM_LAT > 0)) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                // flush aborts the in-flight access without touching memory
                if (flush || r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---- FSM: outputs ----
    // Stall is dropped on flush so upstream does not replay the aborted
    // request, and during reset so nothing is held while the pipe clears.
    always_comb begin
        w_stall    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall    = w_req && (MEM_LAT > 0);
                w_complete = !w_stall;
            end
            ST_WAIT: begin
                w_stall    = (r_cnt != '0);
                w_complete = !w_stall;
            end
            default: ;
        endcase
        if (flush || rst) begin
            w_stall    = 1'b0;
            w_complete = 1'b0;
        end
    end

    assign w_we = w_complete & MemWrite;

    data_mem #(
        .DEPTH    (DEPTH),
        .INIT_HEX (INIT_HEX)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (Dato2),
        .o_rdata (w_rdata)
    );

    // ---- MEM/WB register ----
    // Anything other than a completing access (stall or flush) loads a
    // bubble: WB control cleared, datapath fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb    <= '0;
            r_rdata <= '0;
            r_alu   <= '0;
            r_dst   <= '0;
        end else if (w_complete) begin
            r_wb    <= WB;
            r_rdata <= w_rdata;
            r_alu   <= ALUresult;
            r_dst   <= DirWriteReg;
        end else begin
            r_wb    <= '0;
        end
    end

    assign PCSrc         = Branch & ZeroFlag & ~w_stall;
    assign BranchTarget  = BranchInst;
    assign Stall         = w_stall;
    assign O_WB          = r_wb;
    assign O_ReadData    = r_rdata;
    assign O_ALUresult   = r_alu;
    assign O_DirWriteReg = r_dst;

endmodule
